// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if: first-word-fall-through valid/ready read port of the width-converting FIFO.
interface fifo_rd_ctrl_if #(parameter int RD_WIDTH = 64);
  logic [RD_WIDTH-1:0] dout;
  logic                dout_valid;
  logic                dout_ready;
  modport master (output dout, output dout_valid, input dout_ready);
  modport slave (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller; issues RAM reads, absorbs one-cycle RAM latency into a 2-entry FWFT buffer.
module fifo_rd_ctrl #(
  parameter int RAM_ADDR_WIDTH = 6,
  parameter int RD_WIDTH = 64,
  parameter int RD_IND = 8
) (
  input  logic                      rd_clk,
  input  logic                      rd_rst_n,
  input  logic [RAM_ADDR_WIDTH:0]   wr_ptr_bin,
  output logic [RAM_ADDR_WIDTH-1:0] rd_addr,
  input  logic [RD_WIDTH-1:0]       ram_rd_data,
  output logic [RAM_ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                      empty,
  output logic [RAM_ADDR_WIDTH:0]   avail_cnt,
  fifo_rd_ctrl_if.master            rd
);
  localparam int PW = RAM_ADDR_WIDTH + 1;
  localparam logic [PW-1:0] IND = PW'(RD_IND);
  logic [PW-1:0] rd_ptr, next_rd_ptr;
  logic [1:0] occ, next_occ;
  logic infl, pop, avail, issue, next_avail, slot;
  logic [RD_WIDTH-1:0] buf0, buf1;
  assign rd_addr = rd_ptr[RAM_ADDR_WIDTH-1:0];
  assign rd.dout = buf0;
  assign rd.dout_valid = occ != 2'd0;
  // next_occ counts the in-flight word as already landed, so issuing only while it is below 2 can never overflow
  always_comb begin
    avail_cnt = wr_ptr_bin - rd_ptr;
    avail = avail_cnt >= IND;
    pop = rd.dout_valid & rd.dout_ready;
    next_occ = occ + {1'b0, infl} - {1'b0, pop};
    issue = avail & (next_occ < 2'd2);
    next_rd_ptr = issue ? rd_ptr + IND : rd_ptr;
    next_avail = (wr_ptr_bin - next_rd_ptr) >= IND;
    slot = (occ - {1'b0, pop}) != 2'd0;
  end
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_ptr <= '0;
      rd_ptr_gray <= '0;
      occ <= '0;
      infl <= 1'b0;
      empty <= 1'b1;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      rd_ptr <= next_rd_ptr;
      rd_ptr_gray <= next_rd_ptr ^ (next_rd_ptr >> 1);
      occ <= next_occ;
      infl <= issue;
      empty <= (next_occ == 2'd0) & ~issue & ~next_avail;
      if (pop) buf0 <= buf1;
      if (infl && !slot) buf0 <= ram_rd_data;
      if (infl && slot) buf1 <= ram_rd_data;
    end
  end
  assert property (@(posedge rd_clk) disable iff (!rd_rst_n) !(infl && occ == 2'd2 && !pop));
endmodule
